ps2_key_tracker: RTL and testbench
==================================

// Module: ps2_key_tracker
// PURPOSE
//  Parametrised PS/2 set-2 scancode tracker between PS2_Controller and game logic (blocky).
//  Decodes make, break (F0) and extended (E0) prefixes; keeps a held-state bitmap for
//  NUM_KEYS programmable keys; filters typematic repeats; queues press/release events in a FIFO.
//  Replaces ad-hoc WASD/F0 decoding in the top level. Supports any key set and extended keys.
// PARAMETERS
//  NUM_KEYS        4                   number of tracked keys (>=1)
//  KEY_CODES       32'h23_1B_1C_1D     packed 8*NUM_KEYS scancodes; key i = bits [8i+7:8i]
//  KEY_EXT         4'b0000             per-key flag; 1 = key needs the E0 prefix
//  FIFO_DEPTH      4                   event FIFO entries (power of 2, >=2)
//  PREFIX_TIMEOUT  2500000             idle clocks in a prefix state before abandon (50 ms @ 50 MHz)
// PORTS
//  CLOCK_50      in   1            system clock, all logic on posedge
//  resetn        in   1            asynchronous active-low reset
//  clear         in   1            synchronous flush: bitmap, FIFO, FSM, overflow
//  ps2_data      in   8            received byte from PS2_Controller
//  ps2_valid     in   1            1-cycle strobe qualifying ps2_data
//  key_down      out  NUM_KEYS     held-state bitmap, bit i = key i held
//  key_press     out  NUM_KEYS     1-cycle pulse, key i newly pressed
//  key_release   out  NUM_KEYS     1-cycle pulse, key i newly released
//  evt_valid     out  1            FIFO non-empty (show-ahead)
//  evt_data      out  IW+1         {is_release, key_index}; IW = max(1,$clog2(NUM_KEYS))
//  evt_ready     in   1            consumer pop; pops when evt_valid & evt_ready
//  overflow      out  1            sticky: an event was dropped because FIFO was full
// BEHAVIOUR
//  Reset (async, resetn=0): all outputs 0, FSM=IDLE, FIFO empty, timeout counter 0.
//  Parser FSM, advanced only on ps2_valid:
//   IDLE:   E0->EXT; F0->BRK; other byte->resolve(make, ext=0), stay IDLE
//   EXT:    F0->EXTBRK; E0->stay EXT; other->resolve(make, ext=1), ->IDLE
//   BRK:    E0->EXTBRK; F0->stay BRK; other->resolve(break, ext=0), ->IDLE
//   EXTBRK: E0/F0->stay; other->resolve(break, ext=1), ->IDLE
//  Timeout: in EXT/BRK/EXTBRK, counter increments each clock without ps2_valid, clears
//   on ps2_valid; reaching PREFIX_TIMEOUT-1 forces IDLE, no event generated.
//  Resolve: match i iff byte==KEY_CODES[i] and ext==KEY_EXT[i]; several matches -> lowest
//   i only. No match -> no effect.
//   make & !key_down[i]  -> key_down[i]=1, key_press[i] pulse, push {0,i}
//   make &  key_down[i]  -> typematic repeat: no change, no pulse, no push
//   break & key_down[i]  -> key_down[i]=0, key_release[i] pulse, push {1,i}
//   break & !key_down[i] -> ignored
//  Latency: ps2_valid with final byte at edge n -> key_down, pulses, FIFO write at edge n+1;
//   evt_valid high after edge n+1 if FIFO was empty. Pulses last exactly one cycle.
//  FIFO: show-ahead; evt_data = oldest entry while evt_valid, 0 when empty.
//   Full & push & !pop -> event dropped, overflow<=1; key_down/pulses still update.
//   Full & push & pop -> both happen, no drop. Empty & evt_ready -> no-op.
//   Pointers wrap modulo FIFO_DEPTH; count held in $clog2(FIFO_DEPTH)+1 bits.
//  overflow clears only on reset or clear.
//  clear=1: key_down=0, no pulses, FIFO empty, overflow=0, FSM=IDLE, counter 0; a
//   ps2_valid in the same cycle is discarded. clear takes priority over all else.
//  Reset mid-sequence (e.g. after F0): FSM returns to IDLE; next code is a make.
// TESTING
//  1D, later F0 1D (defaults) -> key_down=0001, key_press[0] pulse, then release[0]; FIFO {0,0},{1,0}
//  1C x5 (typematic) then F0 1C -> one press event, one release event, key_down[1] held in between
//  KEY_EXT=4'b1000, KEY_CODES[31:24]=75: bare 75 -> nothing; E0 75 -> press[3]; E0 F0 75 -> release[3]
//  F0, wait PREFIX_TIMEOUT clocks, then 23 -> treated as make: press[3], no release
//  evt_ready=0, 5 distinct events, FIFO_DEPTH=4 -> 4 queued, overflow=1, key_down still correct;
//   pop+push on full -> no drop
//  1D held, 1B held, assert clear -> key_down=0, evt_valid=0, overflow=0; resetn low after F0 -> IDLE

Source files
------------

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scancode tracker: prefix parser, held-key bitmap with typematic filtering,
// one-cycle press/release pulses and a show-ahead event FIFO with sticky overflow.
module ps2_key_tracker #(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [8*NUM_KEYS-1:0] KEY_CODES      = 32'h23_1B_1C_1D,
  parameter logic [NUM_KEYS-1:0]   KEY_EXT        = '0,
  parameter int                    FIFO_DEPTH     = 4,
  parameter int                    PREFIX_TIMEOUT = 2500000,
  localparam int                   IW             = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                clear,
  input  logic [7:0]          ps2_data,
  input  logic                ps2_valid,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                evt_valid,
  output logic [IW:0]         evt_data,
  input  logic                evt_ready,
  output logic                overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PREFIX_TIMEOUT - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 res_go, res_brk, res_ext;
  logic                 hit;
  logic [IW-1:0]        hit_idx;
  logic                 req_q, req_brk_q;
  logic [IW-1:0]        req_idx_q;
  logic [NUM_KEYS-1:0]  sel;
  logic [NUM_KEYS-1:0]  down_q, down_d, press_q, press_d, rel_q, rel_d;
  logic                 push;
  logic [IW:0]          push_data;
  logic [IW:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          fcnt_q, fcnt_d;
  logic                 ovf_q, ovf_d;
  logic                 pop, full, wr_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_go  = 1'b0;
    res_brk = 1'b0;
    res_ext = 1'b0;
    if (ps2_valid) begin
      cnt_d = '0;
      unique case (state_q)
        S_IDLE: begin
          if (ps2_data == 8'hE0)      state_d = S_EXT;
          else if (ps2_data == 8'hF0) state_d = S_BRK;
          else                        res_go  = 1'b1;
        end
        S_EXT: begin
          if (ps2_data == 8'hF0) state_d = S_EXTBRK;
          else if (ps2_data != 8'hE0) begin
            res_go  = 1'b1;
            res_ext = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          if (ps2_data == 8'hE0) state_d = S_EXTBRK;
          else if (ps2_data != 8'hF0) begin
            res_go  = 1'b1;
            res_brk = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_EXTBRK: begin
          if (ps2_data != 8'hE0 && ps2_data != 8'hF0) begin
            res_go  = 1'b1;
            res_brk = 1'b1;
            res_ext = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      // A stalled prefix is abandoned silently after PREFIX_TIMEOUT idle clocks.
      if (cnt_q == CNT_LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Lowest matching index wins when several table entries share a code.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (!hit && ps2_data == KEY_CODES[8*i +: 8] && KEY_EXT[i] == res_ext) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    sel       = NUM_KEYS'(1) << req_idx_q;
    down_d    = down_q;
    press_d   = '0;
    rel_d     = '0;
    push      = 1'b0;
    push_data = '0;
    if (req_q) begin
      if (!req_brk_q && (down_q & sel) == '0) begin
        down_d    = down_q | sel;
        press_d   = sel;
        push      = 1'b1;
        push_data = {1'b0, req_idx_q};
      end else if (req_brk_q && (down_q & sel) != '0) begin
        down_d    = down_q & ~sel;
        rel_d     = sel;
        push      = 1'b1;
        push_data = {1'b1, req_idx_q};
      end
    end
  end

  always_comb begin
    pop      = evt_ready && (fcnt_q != '0);
    full     = (fcnt_q == FIFO_FULL);
    wr_en    = push && (!full || pop);
    ovf_d    = ovf_q | (push && full && !pop);
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (wr_en && !pop)      fcnt_d = fcnt_q + (AW+1)'(1);
    else if (!wr_en && pop) fcnt_d = fcnt_q - (AW+1)'(1);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      req_brk_q <= 1'b0;
      req_idx_q <= '0;
      down_q    <= '0;
      press_q   <= '0;
      rel_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fcnt_q    <= '0;
      ovf_q     <= 1'b0;
    end else if (clear) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      req_brk_q <= 1'b0;
      req_idx_q <= '0;
      down_q    <= '0;
      press_q   <= '0;
      rel_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fcnt_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= res_go && hit;
      req_brk_q <= res_brk;
      req_idx_q <= hit_idx;
      down_q    <= down_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fcnt_q    <= fcnt_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (wr_en && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign key_down    = down_q;
  assign key_press   = press_q;
  assign key_release = rel_q;
  assign evt_valid   = (fcnt_q != '0);
  assign evt_data    = (fcnt_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: two configurations share one input stream and are checked
// each cycle against a prefix-flag/queue reference model, plus directed vector tables.
module tb_ps2_key_tracker;

  localparam int T = 20;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       clear    = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_valid = 1'b0;
  logic       evt_ready = 1'b1;

  logic [3:0] down_a, press_a, rel_a, down_b, press_b, rel_b;
  logic       ev_a, ev_b, ovf_a, ovf_b;
  logic [2:0] ed_a, ed_b;

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_key_tracker #(
    .NUM_KEYS(4), .KEY_CODES(32'h23_1B_1C_1D), .KEY_EXT(4'b0000),
    .FIFO_DEPTH(4), .PREFIX_TIMEOUT(T)
  ) dut_a (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .clear(clear),
    .ps2_data(ps2_data), .ps2_valid(ps2_valid),
    .key_down(down_a), .key_press(press_a), .key_release(rel_a),
    .evt_valid(ev_a), .evt_data(ed_a), .evt_ready(evt_ready), .overflow(ovf_a)
  );

  ps2_key_tracker #(
    .NUM_KEYS(4), .KEY_CODES(32'h75_1C_1C_1D), .KEY_EXT(4'b1000),
    .FIFO_DEPTH(4), .PREFIX_TIMEOUT(T)
  ) dut_b (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .clear(clear),
    .ps2_data(ps2_data), .ps2_valid(ps2_valid),
    .key_down(down_b), .key_press(press_b), .key_release(rel_b),
    .evt_valid(ev_b), .evt_data(ed_b), .evt_ready(evt_ready), .overflow(ovf_b)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: parser kept as "seen E0" / "seen F0" flags, FIFO as a queue.
  logic [7:0] mcode [2][4];
  logic       mext  [2][4];
  logic [3:0] md [2], mp [2], mr [2];
  logic       mo [2];
  logic [2:0] mq [2][$];
  logic       e0f, f0f, pend_v, pend_brk, pend_ext;
  logic [7:0] pend_byte;
  int         idle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      md[m] = '0; mp[m] = '0; mr[m] = '0; mo[m] = 1'b0;
      mq[m].delete();
    end
    e0f = 1'b0; f0f = 1'b0; pend_v = 1'b0; pend_brk = 1'b0; pend_ext = 1'b0;
    pend_byte = '0; idle = 0;
  endtask

  task automatic model_step();
    int  pre, fi;
    bit  found, popm, pushm;
    logic [2:0] ev;
    if (!resetn || clear) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      mp[m] = '0; mr[m] = '0;
      pre = mq[m].size();
      popm = evt_ready && (pre > 0);
      pushm = 1'b0; ev = '0;
      if (pend_v) begin
        found = 1'b0; fi = 0;
        for (int i = 0; i < 4; i++)
          if (!found && mcode[m][i] == pend_byte && mext[m][i] == pend_ext) begin
            found = 1'b1; fi = i;
          end
        if (found && !pend_brk && !md[m][fi]) begin
          md[m][fi] = 1'b1; mp[m][fi] = 1'b1; pushm = 1'b1; ev = {1'b0, 2'(fi)};
        end else if (found && pend_brk && md[m][fi]) begin
          md[m][fi] = 1'b0; mr[m][fi] = 1'b1; pushm = 1'b1; ev = {1'b1, 2'(fi)};
        end
      end
      if (popm) void'(mq[m].pop_front());
      if (pushm) begin
        if (pre == 4 && !popm) mo[m] = 1'b1;
        else mq[m].push_back(ev);
      end
    end
    pend_v = 1'b0;
    if (ps2_valid) begin
      idle = 0;
      if (ps2_data == 8'hE0) e0f = 1'b1;
      else if (ps2_data == 8'hF0) f0f = 1'b1;
      else begin
        pend_v = 1'b1; pend_byte = ps2_data; pend_brk = f0f; pend_ext = e0f;
        e0f = 1'b0; f0f = 1'b0;
      end
    end else if (e0f || f0f) begin
      idle++;
      if (idle >= T) begin e0f = 1'b0; f0f = 1'b0; idle = 0; end
    end else begin
      idle = 0;
    end
  endtask

  task automatic compare_all();
    logic [2:0] ea, eb;
    ea = (mq[0].size() > 0) ? mq[0][0] : 3'b000;
    eb = (mq[1].size() > 0) ? mq[1][0] : 3'b000;
    chk("model_down_a", 32'(down_a), 32'(md[0]));
    chk("model_press_a", 32'(press_a), 32'(mp[0]));
    chk("model_rel_a", 32'(rel_a), 32'(mr[0]));
    chk("model_evv_a", 32'(ev_a), 32'(mq[0].size() > 0));
    chk("model_evd_a", 32'(ed_a), 32'(ea));
    chk("model_ovf_a", 32'(ovf_a), 32'(mo[0]));
    chk("model_down_b", 32'(down_b), 32'(md[1]));
    chk("model_press_b", 32'(press_b), 32'(mp[1]));
    chk("model_rel_b", 32'(rel_b), 32'(mr[1]));
    chk("model_evv_b", 32'(ev_b), 32'(mq[1].size() > 0));
    chk("model_evd_b", 32'(ed_b), 32'(eb));
    chk("model_ovf_b", 32'(ovf_b), 32'(mo[1]));
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    model_step();
    @(negedge CLOCK_50);
    compare_all();
  endtask

  // One strobed byte, then one idle cycle so the resolved result is visible.
  task automatic send(input logic [7:0] b);
    ps2_data = b; ps2_valid = 1'b1;
    tick();
    ps2_valid = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [7:0] b;
    logic [3:0] da, pa, ra, db, pb, rb;
  } vec_t;

  vec_t       tbl [22];
  logic [7:0] pool [9];
  logic [2:0] drain_exp [4];

  initial begin
    mcode[0][0] = 8'h1D; mcode[0][1] = 8'h1C; mcode[0][2] = 8'h1B; mcode[0][3] = 8'h23;
    mcode[1][0] = 8'h1D; mcode[1][1] = 8'h1C; mcode[1][2] = 8'h1C; mcode[1][3] = 8'h75;
    for (int i = 0; i < 4; i++) begin mext[0][i] = 1'b0; mext[1][i] = (i == 3); end
    model_reset();

    tbl[0]  = '{8'h1D, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    tbl[1]  = '{8'hF0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    tbl[2]  = '{8'h1D, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
    tbl[3]  = '{8'h1C, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
    tbl[4]  = '{8'h1C, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    tbl[5]  = '{8'h1C, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    tbl[6]  = '{8'hF0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    tbl[7]  = '{8'h1C, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010};
    tbl[8]  = '{8'h75, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[9]  = '{8'hE0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[10] = '{8'h75, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
    tbl[11] = '{8'hE0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    tbl[12] = '{8'hF0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    tbl[13] = '{8'h75, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
    tbl[14] = '{8'hE0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[15] = '{8'h1D, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[16] = '{8'h23, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[17] = '{8'hE0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[18] = '{8'hF0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[19] = '{8'h23, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[20] = '{8'hF0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[21] = '{8'h23, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};

    pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'hE0, 8'hF0, 8'hE0, 8'hF0};
    drain_exp = '{3'b001, 3'b010, 3'b011, 3'b100};

    repeat (3) tick();
    resetn = 1'b1;
    tick();
    chk("reset_down", 32'(down_a), 32'h0);
    chk("reset_evv", 32'(ev_a), 32'h0);
    chk("reset_ovf", 32'(ovf_a), 32'h0);

    // Directed byte table: make/break, typematic, extended keys, duplicate codes.
    for (int k = 0; k < 22; k++) begin
      send(tbl[k].b);
      chk($sformatf("tbl%0d_down_a", k), 32'(down_a), 32'(tbl[k].da));
      chk($sformatf("tbl%0d_press_a", k), 32'(press_a), 32'(tbl[k].pa));
      chk($sformatf("tbl%0d_rel_a", k), 32'(rel_a), 32'(tbl[k].ra));
      chk($sformatf("tbl%0d_down_b", k), 32'(down_b), 32'(tbl[k].db));
      chk($sformatf("tbl%0d_press_b", k), 32'(press_b), 32'(tbl[k].pb));
      chk($sformatf("tbl%0d_rel_b", k), 32'(rel_b), 32'(tbl[k].rb));
    end

    // Prefix timeout: a short gap keeps the break, a long gap turns 23 into a make.
    send(8'h23);
    send(8'hF0);
    repeat (T - 5) tick();
    send(8'h23);
    chk("short_gap_rel", 32'(rel_a), 32'h8);
    chk("short_gap_down", 32'(down_a), 32'h0);
    send(8'hF0);
    repeat (T + 2) tick();
    send(8'h23);
    chk("timeout_press", 32'(press_a), 32'h8);
    chk("timeout_down", 32'(down_a), 32'h8);

    // FIFO full, simultaneous push and pop on full, drain order, then overflow.
    clear = 1'b1; tick(); clear = 1'b0;
    evt_ready = 1'b0;
    send(8'h1D); send(8'h1C); send(8'h1B); send(8'h23);
    chk("full_head", 32'(ed_a), 32'h0);
    chk("full_ovf", 32'(ovf_a), 32'h0);
    send(8'hF0);
    ps2_data = 8'h1D; ps2_valid = 1'b1;
    tick();
    ps2_valid = 1'b0; evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("pushpop_ovf", 32'(ovf_a), 32'h0);
    chk("pushpop_down", 32'(down_a), 32'he);
    evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d", k), 32'(ed_a), 32'(drain_exp[k]));
      tick();
    end
    chk("drain_empty", 32'(ev_a), 32'h0);
    evt_ready = 1'b0;
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h1B);
    send(8'hF0); send(8'h23); send(8'h1D); send(8'h1C);
    chk("ovf_set", 32'(ovf_a), 32'h1);
    chk("ovf_down", 32'(down_a), 32'h3);
    chk("ovf_head", 32'(ed_a), 32'h5);
    chk("ovf_valid", 32'(ev_a), 32'h1);

    // clear wins over a coincident byte.
    clear = 1'b1; ps2_data = 8'h1B; ps2_valid = 1'b1;
    tick();
    clear = 1'b0; ps2_valid = 1'b0;
    tick();
    chk("clear_down", 32'(down_a), 32'h0);
    chk("clear_evv", 32'(ev_a), 32'h0);
    chk("clear_ovf", 32'(ovf_a), 32'h0);

    // Reset after F0 leaves the parser idle, so 1D is a make.
    evt_ready = 1'b1;
    send(8'hF0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    send(8'h1D);
    chk("rst_mid_press", 32'(press_a), 32'h1);
    chk("rst_mid_down", 32'(down_a), 32'h1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      clear     = ($urandom_range(0, 99) == 0);
      evt_ready = $urandom_range(0, 1) == 1;
      ps2_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) ps2_data = 8'($urandom);
      else ps2_data = pool[$urandom_range(0, 8)];
      tick();
    end
    clear = 1'b0; ps2_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
